// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg: shared defaults and sizing helpers for the handshake arbiter family.
package hs_arb_pkg;
  localparam int HS_DEFAULT_N_REQ = 3;
  localparam int HS_DEFAULT_DATA_W = 4;
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  typedef logic [clog2_min1(HS_DEFAULT_N_REQ)-1:0] hs_src_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick; rotate past last grant, fixed-priority encode, rotate back.
module rr_pick
  import hs_arb_pkg::*;
#(
  parameter int N_REQ = HS_DEFAULT_N_REQ,
  localparam int SRC_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible_i,
  input  logic [SRC_W-1:0] last_grant_i,
  output logic             found_o,
  output logic [SRC_W-1:0] winner_o,
  output logic [N_REQ-1:0] grant_o
);
  logic [SRC_W:0] base;
  logic [SRC_W:0] sum;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0] rot;
  logic [SRC_W-1:0] off;
  always_comb begin
    base = {1'b0, last_grant_i} + (SRC_W+1)'(1);
    dbl = {eligible_i, eligible_i} >> base;
    rot = dbl[N_REQ-1:0];
    found_o = |rot;
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (rot[i]) off = SRC_W'(i);
    // base + off never exceeds 2*N_REQ-1, so a single subtraction is the modulo
    sum = base + {1'b0, off};
    winner_o = (sum >= (SRC_W+1)'(N_REQ)) ? SRC_W'(sum - (SRC_W+1)'(N_REQ)) : SRC_W'(sum);
    grant_o = found_o ? N_REQ'(1) << winner_o : '0;
  end
endmodule

// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: round-robin mux of N_REQ ready/valid requesters into one registered output stage.
module hs_rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter int N_REQ = HS_DEFAULT_N_REQ,
  parameter int DATA_W = HS_DEFAULT_DATA_W,
  localparam int SRC_W = clog2_min1(N_REQ)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [SRC_W-1:0]        out_src
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic [SRC_W-1:0]  last_q, last_d;
  logic              load, found, take;
  logic [SRC_W-1:0]  winner;
  logic [N_REQ-1:0]  grant;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .eligible_i  (req_valid & req_mask),
    .last_grant_i(last_q),
    .found_o     (found),
    .winner_o    (winner),
    .grant_o     (grant)
  );

  always_comb begin
    load = !valid_q || out_ready;
    take = load && found && !RESET;
    req_ready = take ? grant : '0;
    valid_d = load ? found : valid_q;
    data_d = take ? req_data[winner*DATA_W +: DATA_W] : data_q;
    src_d = take ? winner : src_q;
    last_d = take ? winner : last_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= 1'b0;
      data_q <= '0;
      src_q <= '0;
      last_q <= SRC_W'(N_REQ - 1);
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      src_q <= src_d;
      last_q <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data = data_q;
  assign out_src = src_q;
endmodule

// File: tb/tb_hs_rr_arbiter.sv
// tb_hs_rr_arbiter: table-driven cycle vectors with an output scoreboard for hs_rr_arbiter.
module tb_hs_rr_arbiter;
  logic        CLK = 1'b0;
  logic        RESET;
  logic [2:0]  req_valid, req_ready, req_mask;
  logic [11:0] req_data;
  logic        out_valid, out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_src;

  hs_rr_arbiter dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .req_mask (req_mask),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_src  (out_src)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rst;
    logic [2:0]  v;
    logic [2:0]  m;
    logic        o;
    logic [11:0] d;
    logic [2:0]  er;
    logic        eo;
  } vec_t;

  typedef struct packed {
    logic [1:0] src;
    logic [3:0] data;
  } ent_t;

  vec_t tbl[30];
  ent_t sb[$];
  ent_t e;
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic rst, input logic [2:0] v, input logic [2:0] m,
                              input logic o, input logic [11:0] d, input logic [2:0] er,
                              input logic eo);
    return '{rst: rst, v: v, m: m, o: o, d: d, er: er, eo: eo};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    // all-valid fairness, then req0=A held through a 3-cycle stall
    tbl[0] = mk(0, 3'b111, 3'b111, 1, 12'h32A, 3'b001, 0);
    tbl[1] = mk(0, 3'b111, 3'b111, 1, 12'h32A, 3'b010, 1);
    tbl[2] = mk(0, 3'b111, 3'b111, 1, 12'h32A, 3'b100, 1);
    tbl[3] = mk(0, 3'b111, 3'b111, 1, 12'h32A, 3'b001, 1);
    tbl[4] = mk(0, 3'b110, 3'b111, 0, 12'h32A, 3'b000, 1);
    tbl[5] = mk(0, 3'b110, 3'b111, 0, 12'h32A, 3'b000, 1);
    tbl[6] = mk(0, 3'b110, 3'b111, 0, 12'h32A, 3'b000, 1);
    tbl[7] = mk(0, 3'b110, 3'b111, 1, 12'h32A, 3'b010, 1);
    // sparse with wrap-around, then drain to empty
    tbl[8] = mk(0, 3'b100, 3'b111, 1, 12'h32A, 3'b100, 1);
    tbl[9] = mk(0, 3'b010, 3'b111, 1, 12'h35A, 3'b010, 1);
    tbl[10] = mk(0, 3'b000, 3'b111, 1, 12'h35A, 3'b000, 1);
    tbl[11] = mk(0, 3'b000, 3'b111, 1, 12'h35A, 3'b000, 0);
    // requester 1 masked out
    tbl[12] = mk(0, 3'b111, 3'b101, 1, 12'h32A, 3'b100, 0);
    tbl[13] = mk(0, 3'b111, 3'b101, 1, 12'h32A, 3'b001, 1);
    tbl[14] = mk(0, 3'b111, 3'b101, 1, 12'h32A, 3'b100, 1);
    tbl[15] = mk(0, 3'b111, 3'b101, 1, 12'h32A, 3'b001, 1);
    // reset while an entry is stalled
    tbl[16] = mk(0, 3'b111, 3'b111, 0, 12'h32A, 3'b000, 1);
    tbl[17] = mk(1, 3'b111, 3'b111, 0, 12'h32A, 3'b000, 1);
    tbl[18] = mk(0, 3'b111, 3'b111, 1, 12'h32A, 3'b001, 0);
    tbl[19] = mk(0, 3'b111, 3'b111, 1, 12'h32A, 3'b010, 1);
    // requester 2 streaming 0..7 back to back
    for (int k = 0; k < 8; k++) tbl[20+k] = mk(0, 3'b100, 3'b111, 1, {4'(k), 8'h2A}, 3'b100, 1);
    tbl[28] = mk(0, 3'b000, 3'b111, 1, 12'h72A, 3'b000, 1);
    tbl[29] = mk(0, 3'b000, 3'b111, 1, 12'h72A, 3'b000, 0);

    RESET = 1'b1;
    req_valid = 3'b111;
    req_mask = 3'b111;
    req_data = 12'h32A;
    out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_src", int'(out_src), 0);

    for (int r = 0; r < 30; r++) begin
      @(negedge CLK);
      RESET = tbl[r].rst;
      req_valid = tbl[r].v;
      req_mask = tbl[r].m;
      out_ready = tbl[r].o;
      req_data = tbl[r].d;
      #1;
      chk($sformatf("row%0d req_ready", r), int'(req_ready), int'(tbl[r].er));
      chk($sformatf("row%0d out_valid", r), int'(out_valid), int'(tbl[r].eo));
      if (out_valid) begin
        if (sb.size() == 0) chk($sformatf("row%0d sb_nonempty", r), 0, 1);
        else begin
          chk($sformatf("row%0d out_src", r), int'(out_src), int'(sb[0].src));
          chk($sformatf("row%0d out_data", r), int'(out_data), int'(sb[0].data));
          if (out_ready && !tbl[r].rst) void'(sb.pop_front());
        end
      end
      if (!tbl[r].rst)
        for (int i = 0; i < 3; i++)
          if (tbl[r].er[i]) begin
            e.src = 2'(i);
            e.data = tbl[r].d[i*4 +: 4];
            sb.push_back(e);
          end
      if (tbl[r].rst) sb.delete();
    end
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hs_rr_arbiter.md
Name: hs_rr_arbiter

Overview:
- Round-robin arbiter that shares one ready/valid output channel between N_REQ ready/valid requesters, each carrying a DATA_W payload.
- The output is a one-entry registered stage: full throughput, one cycle of latency.
- Sits in front of a shared handshake consumer, for example the datapath observed by the handshake Monitor. Its out_* port maps to the handshake_valid/handshake_ready pair, and its req_* ports map to handshake_arr_0..2.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- DATA_W, 4, payload width per requester.
- SRC_W, $clog2(N_REQ), width of the source index (derived; not overridable).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester valid.
- req_ready  out  N_REQ  per-requester ready.
- req_data  in  N_REQ*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_mask  in  N_REQ  1 = requester i is eligible; 0 = excluded from arbitration.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_W  registered winning payload.
- out_src  out  SRC_W  index of the requester that produced out_data.

Behaviour:
- Reset: the clock is CLK; reset is synchronous and active-high on RESET.
  - out_valid=0, out_data=0, out_src=0.
  - last_grant=N_REQ-1, so requester 0 has top priority first.
  - req_ready is 0 while RESET=1.
  - A reset mid-transfer discards the held entry; no handshake completes in that cycle.
- Handshake:
  - A transfer occurs on any cycle with valid&&ready at rising CLK.
  - After out_valid rises, out_data and out_src stay stable until out_ready=1.
- load = !out_valid || out_ready (the entry is empty or draining this cycle).
- eligible[i] = req_valid[i] && req_mask[i].
- Winner: the first eligible index scanning (last_grant+1) mod N_REQ upward, with wrap-around. Combinational.
- req_ready:
  - req_ready[w]=1 only when load=1, an eligible winner w exists, and RESET=0.
  - Every other req_ready bit is 0. At most one bit is high (one-hot or zero).
- On a grant (load && eligible winner w):
  - out_data<=req_data[w], out_src<=w, out_valid<=1, last_grant<=w.
- load with no eligible requester: out_valid<=0. out_data/out_src hold their old values; they are don't-care.
- !load (stalled):
  - All req_ready=0 and the entry holds.
  - last_grant is unchanged; priority is not consumed by stall cycles.
- Simultaneous drain and refill (out_valid&&out_ready and an eligible winner): the new entry loads in the same cycle, giving back-to-back transfers at 1/cycle.
- Latency: a requester handshake at cycle t produces out_valid with its data at cycle t+1.
- Fairness: with all requesters continuously eligible, the grant order is 0,1,2,0,1,2,... Each requester waits at most N_REQ-1 grants.
- Masking:
  - Deasserting req_mask[i] removes i from arbitration from the same cycle.
  - An entry already held in the output register is unaffected.
- Combinational paths: req_ready depends on req_valid, req_mask and out_ready.
  - Requesters must not derive req_valid from req_ready (standard ready/valid rule).
  - out_valid, out_data and out_src are purely registered.

Decomposition:
- Package hs_arb_pkg:
  - localparams HS_DEFAULT_N_REQ=3, HS_DEFAULT_DATA_W=4.
  - function clog2_min1 (returns 1 for N=1).
  - typedef hs_src_t sized for the default.
- Sub-module rr_pick (combinational):
  - Inputs: eligible[N_REQ] and last_grant.
  - Outputs: found, winner index, and one-hot grant.
  - Implemented as a rotate, fixed-priority encode, rotate back.
  - Reusable by future schedulers.

Test Plan:
1. Reset priority: RESET held 2 cycles, then all req_valid=3'b111, mask=3'b111, out_ready=1. Expected: out_src sequence 0,1,2,0; req_ready one-hot 001,010,100,001; out_valid=1 from the 2nd cycle onward.
2. Stall hold: req0 data=4'hA granted, out_ready=0 for 3 cycles while req1/req2 are valid. Expected: out_data=4'hA, out_src=0 stable; req_ready=000 throughout. On out_ready=1, req1 data loads the next cycle.
3. Sparse and wrap-around: after last_grant=2, only req_valid[1]=1 (data 4'h5). Expected: req_ready=010, out_data=4'h5 at t+1. Then with no valid and out_ready=1, out_valid drops to 0.
4. Mask: mask=3'b101, all valid. Expected: grants alternate 0,2,0,2; req_ready[1] never asserts; out_src never equals 1.
5. Reset mid-operation: out_valid=1 with out_ready=0, then RESET pulsed for 1 cycle. Expected: next cycle out_valid=0, req_ready=000 during reset; after release, requester 0 wins first.
6. Back-to-back throughput: req2 alone continuously valid with incrementing data 0..7 and out_ready=1. Expected: out_data 0..7 on consecutive cycles with 1-cycle latency, and no bubbles.
